// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: width helper,
// default PC constants and the read-port slice helper.
package regfile_pkg;

  // Default PC advance per pc_inc cycle and ARM-style pipeline read offset.
  localparam int unsigned DEF_PC_STEP   = 4;
  localparam int unsigned DEF_PC_RD_OFS = 8;

  // Ceiling log2, used to size register addresses from NREGS.
  function automatic int clog2(input int unsigned n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Bit offset of read port idx within a packed bus of w-bit fields.
  function automatic int port_lsb(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by an accepted
// reservation and cleared by a write to that register.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  output logic             rsv_ready,
  output logic [NREGS-1:0] busy_vec
);

  logic [NREGS-1:0] busy_nxt;

  // A reservation is only accepted when the register is idle; the ready flag
  // deliberately ignores a same-cycle write so a clear is never bypassed.
  assign rsv_ready = ~busy_vec[rsv_addr];

  // Next busy state: clear on write first, then set on accepted reservation
  // so a simultaneous write+reserve to one register leaves it pending.
  always_comb begin
    busy_nxt = busy_vec;
    if (wr_en)
      busy_nxt[wr_addr] = 1'b0;
    if (rsv_en && rsv_ready)
      busy_nxt[rsv_addr] = 1'b1;
  end

  // Busy register, cleared immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      busy_vec <= '0;
    else
      busy_vec <= busy_nxt;
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with write-to-read bypass, a
// program-counter register with auto-increment and read offset, and a
// pending-write scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          NREGS     = 16,
  parameter int          N_RD      = 2,
  parameter int          PC_IDX    = NREGS - 1,
  parameter int unsigned RESET_PC  = 0,
  parameter int unsigned PC_STEP   = DEF_PC_STEP,
  parameter int unsigned PC_RD_OFS = DEF_PC_RD_OFS,
  parameter bit          BYPASS    = 1'b1,
  localparam int         AW        = clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_RD*AW-1:0]       rd_addr,
  output logic [N_RD*DATA_W-1:0]   rd_data,
  output logic [N_RD-1:0]          rd_busy,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     pc_inc,
  output logic [DATA_W-1:0]        pc_out,
  input  logic                     rsv_en,
  input  logic [AW-1:0]            rsv_addr,
  output logic                     rsv_ready,
  output logic [NREGS-1:0]         busy_vec
);

  localparam logic [AW-1:0]     PC_A    = AW'(PC_IDX);
  localparam logic [DATA_W-1:0] PC_RST  = DATA_W'(RESET_PC);
  localparam logic [DATA_W-1:0] PC_INCR = DATA_W'(PC_STEP);
  localparam logic [DATA_W-1:0] PC_OFS  = DATA_W'(PC_RD_OFS);

  logic [DATA_W-1:0] regs [NREGS];
  logic              pc_wr;

  // A direct write to the PC outranks auto-increment.
  assign pc_wr  = wr_en && (wr_addr == PC_A);
  assign pc_out = regs[PC_IDX];

  // Register storage and PC update; reset clears everything but the PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++)
        regs[r] <= (r == PC_IDX) ? PC_RST : '0;
    end else begin
      if (wr_en)
        regs[wr_addr] <= wr_data;
      if (pc_inc && !pc_wr)
        regs[PC_IDX] <= regs[PC_IDX] + PC_INCR;
    end
  end

  // Combinational read ports with optional same-cycle write forwarding and
  // the PC read offset applied after forwarding.
  always_comb begin
    logic [AW-1:0]     a;
    logic [DATA_W-1:0] v;
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < N_RD; p++) begin
      a = rd_addr[port_lsb(p, AW) +: AW];
      v = regs[a];
      if (BYPASS && wr_en && (wr_addr == a))
        v = wr_data;
      if (a == PC_A)
        v = v + PC_OFS;
      rd_data[port_lsb(p, DATA_W) +: DATA_W] = v;
      rd_busy[p] = busy_vec[a];
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .rsv_ready (rsv_ready),
    .busy_vec  (busy_vec)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default 16x32 instance plus a 32x16
// three-read-port instance.
module tb_regfile_mp;

  logic clk;
  logic rst_n;

  // Default instance (16 x 32, two read ports)
  logic [7:0]  rd_addr0;
  logic [63:0] rd_data0;
  logic [1:0]  rd_busy0;
  logic        wr_en0;
  logic [3:0]  wr_addr0;
  logic [31:0] wr_data0;
  logic        pc_inc0;
  logic [31:0] pc_out0;
  logic        rsv_en0;
  logic [3:0]  rsv_addr0;
  logic        rsv_ready0;
  logic [15:0] busy_vec0;

  // Wide instance (32 x 16, three read ports)
  logic [14:0] rd_addr1;
  logic [47:0] rd_data1;
  logic [2:0]  rd_busy1;
  logic        wr_en1;
  logic [4:0]  wr_addr1;
  logic [15:0] wr_data1;
  logic        pc_inc1;
  logic [15:0] pc_out1;
  logic        rsv_en1;
  logic [4:0]  rsv_addr1;
  logic        rsv_ready1;
  logic [31:0] busy_vec1;

  int n_cmp;
  int n_err;

  regfile_mp dut0 (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr0), .rd_data(rd_data0), .rd_busy(rd_busy0),
    .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .pc_inc(pc_inc0), .pc_out(pc_out0),
    .rsv_en(rsv_en0), .rsv_addr(rsv_addr0), .rsv_ready(rsv_ready0),
    .busy_vec(busy_vec0)
  );

  regfile_mp #(.DATA_W(16), .NREGS(32), .N_RD(3)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr1), .rd_data(rd_data1), .rd_busy(rd_busy1),
    .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .pc_inc(pc_inc1), .pc_out(pc_out1),
    .rsv_en(rsv_en1), .rsv_addr(rsv_addr1), .rsv_ready(rsv_ready1),
    .busy_vec(busy_vec1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge, leaving time to drive inputs.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    rd_addr0 = '0; wr_en0 = 0; wr_addr0 = '0; wr_data0 = '0;
    pc_inc0 = 0; rsv_en0 = 0; rsv_addr0 = '0;
    rd_addr1 = '0; wr_en1 = 0; wr_addr1 = '0; wr_data1 = '0;
    pc_inc1 = 0; rsv_en1 = 0; rsv_addr1 = '0;
    step();
    step();
    rst_n = 1'b1;
    step();

    // Write R3 with bypass on the write cycle, then from storage
    rd_addr0 = {4'd0, 4'd3};
    wr_en0 = 1; wr_addr0 = 4'd3; wr_data0 = 32'hDEADBEEF;
    #1;
    chk("bypass_r3", rd_data0[31:0], 32'hDEADBEEF);
    chk("r0_zero", rd_data0[63:32], 32'h0);
    step();
    wr_en0 = 0;
    #1;
    chk("stored_r3", rd_data0[31:0], 32'hDEADBEEF);

    // Five PC increments from reset
    pc_inc0 = 1;
    for (int k = 0; k < 5; k++) step();
    pc_inc0 = 0;
    rd_addr0 = {4'd0, 4'd15};
    #1;
    chk("pc_after5", pc_out0, 32'd20);
    chk("pc_read_ofs", rd_data0[31:0], 32'd28);

    // Write to PC outranks increment; bypassed PC read includes offset
    wr_en0 = 1; wr_addr0 = 4'd15; wr_data0 = 32'h100; pc_inc0 = 1;
    #1;
    chk("pc_bypass_ofs", rd_data0[31:0], 32'h108);
    step();
    wr_en0 = 0; pc_inc0 = 0;
    #1;
    chk("pc_wr_prio", pc_out0, 32'h100);

    // PC wrap
    wr_en0 = 1; wr_addr0 = 4'd15; wr_data0 = 32'hFFFFFFFC;
    step();
    wr_en0 = 0; pc_inc0 = 1;
    step();
    pc_inc0 = 0;
    #1;
    chk("pc_wrap", pc_out0, 32'h0);
    chk("pc_wrap_read", rd_data0[31:0], 32'h8);

    // Scoreboard: reserve R5
    rsv_addr0 = 4'd5;
    rd_addr0 = {4'd0, 4'd5};
    #1;
    chk("rsv_ready_idle", rsv_ready0, 1'b1);
    rsv_en0 = 1;
    step();
    #1;
    chk("busy_r5", busy_vec0, 16'h0020);
    chk("rsv_ready_busy", rsv_ready0, 1'b0);
    chk("rd_busy_r5", rd_busy0[0], 1'b1);
    step();
    rsv_en0 = 0;
    #1;
    chk("rsv_ignored", busy_vec0, 16'h0020);

    // Write clears busy next cycle, not combinationally
    wr_en0 = 1; wr_addr0 = 4'd5; wr_data0 = 32'h55;
    #1;
    chk("no_clear_bypass", rsv_ready0, 1'b0);
    step();
    wr_en0 = 0;
    #1;
    chk("busy_cleared", busy_vec0, 16'h0000);

    // Same-cycle write + reserve R5: data updated, still busy
    wr_en0 = 1; wr_addr0 = 4'd5; wr_data0 = 32'h77; rsv_en0 = 1;
    step();
    wr_en0 = 0; rsv_en0 = 0;
    #1;
    chk("wr_rsv_same_busy", busy_vec0, 16'h0020);
    chk("wr_rsv_same_data", rd_data0[31:0], 32'h77);

    // Write R5 (clears) while reserving R6
    wr_en0 = 1; wr_addr0 = 4'd5; wr_data0 = 32'h99;
    rsv_en0 = 1; rsv_addr0 = 4'd6;
    step();
    wr_en0 = 0; rsv_en0 = 0;
    #1;
    chk("wr_rsv_diff", busy_vec0, 16'h0040);

    // Wide instance: three independent reads, offset only on R31 port
    wr_en1 = 1; wr_addr1 = 5'd17; wr_data1 = 16'h1111;
    step();
    wr_addr1 = 5'd31; wr_data1 = 16'h2222;
    step();
    wr_addr1 = 5'd0; wr_data1 = 16'h3333;
    step();
    wr_en1 = 0;
    rd_addr1 = {5'd31, 5'd17, 5'd0};
    #1;
    chk("w_port0_r0", rd_data1[15:0], 16'h3333);
    chk("w_port1_r17", rd_data1[31:16], 16'h1111);
    chk("w_port2_r31", rd_data1[47:32], 16'h222A);
    chk("w_pc_out", pc_out1, 16'h2222);

    // Reset asserted mid-cycle overrides pending write/reservation
    rsv_addr0 = 4'd7;
    wr_en0 = 1; wr_addr0 = 4'd3; wr_data0 = 32'h1234; rsv_en0 = 1;
    #1;
    rst_n = 1'b0;
    step();
    wr_en0 = 0; rsv_en0 = 0;
    rd_addr0 = {4'd0, 4'd3};
    #1;
    chk("rst_r3", rd_data0[31:0], 32'h0);
    chk("rst_r0", rd_data0[63:32], 32'h0);
    chk("rst_pc", pc_out0, 32'h0);
    chk("rst_busy", busy_vec0, 16'h0000);
    chk("rst_rsv_ready", rsv_ready0, 1'b1);
    chk("rst_rd_busy", rd_busy0, 2'b00);
    chk("rst_wide_r17", rd_data1[31:16], 16'h0);

    // First write after release takes effect at the next edge
    rst_n = 1'b1;
    wr_en0 = 1; wr_addr0 = 4'd3; wr_data0 = 32'hA5A5;
    step();
    wr_en0 = 0;
    #1;
    chk("post_rst_wr", rd_data0[31:0], 32'hA5A5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
